jtcop_objdma: RTL and testbench



---
 rtl/jtcop_objdma.sv | 78 +++++++
 tb/tb_jtcop_objdma.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_objdma.sv
// Object-RAM copy engine: on a CPU trigger, snapshots the whole object table into the
// renderer's private copy, optionally waiting for vertical blank first.
module jtcop_objdma #(
   parameter int unsigned AW     = 10,
   parameter bit          VBWAIT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          obj_copy,
   input  logic          LVBL,
   output logic [AW-1:0] src_addr,
   input  logic [15:0]   src_data,
   output logic [AW-1:0] dst_addr,
   output logic [15:0]   dst_dout,
   output logic          dst_we,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {StIdle, StWaitVb, StCopy, StFlush} state_t;

   localparam logic [AW-1:0] CntOne  = AW'(1);
   localparam logic [AW-1:0] CntLast = '1;

   state_t        state;
   logic          copy_l;
   logic          req;
   logic [AW-1:0] rd_cnt;
   logic          trig;

   assign trig     = obj_copy & ~copy_l;
   assign src_addr = rd_cnt;
   // RAM is synchronous, so its output already lines up with the delayed write strobe
   assign dst_dout = src_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         copy_l   <= 1'b0;
         req      <= 1'b0;
         rd_cnt   <= '0;
         dst_addr <= '0;
         dst_we   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         copy_l   <= obj_copy;
         dst_addr <= rd_cnt;
         dst_we   <= (state == StCopy);
         done     <= 1'b0;
         unique case (state)
            StIdle: begin
               if (req) begin
                  req   <= 1'b0;
                  busy  <= 1'b1;
                  state <= VBWAIT ? StWaitVb : StCopy;
               end
            end
            StWaitVb: begin
               if (!LVBL) state <= StCopy;
            end
            StCopy: begin
               rd_cnt <= rd_cnt + CntOne;
               if (rd_cnt == CntLast) state <= StFlush;
            end
            StFlush: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
         // A new edge wins over the clear above; while busy it is held as the pending copy
         if (trig) req <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jtcop_objdma.sv
// Bench for jtcop_objdma: one instance without and one with vertical-blank wait, each
// fed by a synchronous source RAM model; writes are checked against a per-instance queue.
module tb_jtcop_objdma;

   localparam int unsigned AW = 10;
   localparam int unsigned NW = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic          obj_copy0 = 1'b0, obj_copy1 = 1'b0;
   logic          lvbl1 = 1'b1;
   logic [AW-1:0] src_addr0, src_addr1, dst_addr0, dst_addr1;
   logic [15:0]   src_data0, src_data1, dst_dout0, dst_dout1;
   logic          dst_we0, dst_we1, busy0, busy1, done0, done1;

   jtcop_objdma #(.AW(AW), .VBWAIT(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .obj_copy(obj_copy0), .LVBL(1'b1),
      .src_addr(src_addr0), .src_data(src_data0), .dst_addr(dst_addr0),
      .dst_dout(dst_dout0), .dst_we(dst_we0), .busy(busy0), .done(done0)
   );

   jtcop_objdma #(.AW(AW), .VBWAIT(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .obj_copy(obj_copy1), .LVBL(lvbl1),
      .src_addr(src_addr1), .src_data(src_data1), .dst_addr(dst_addr1),
      .dst_dout(dst_dout1), .dst_we(dst_we1), .busy(busy1), .done(done1)
   );

   // Source RAM: word k holds k ^ 16'hA5A5, one clock read latency
   always @(posedge clk) begin
      src_data0 <= {6'd0, src_addr0} ^ 16'hA5A5;
      src_data1 <= {6'd0, src_addr1} ^ 16'hA5A5;
   end

   logic [AW+15:0] q0[$];
   logic [AW+15:0] q1[$];
   int we_cnt0 = 0, we_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;

   task automatic push_copy(input int inst);
      for (int k = 0; k < int'(NW); k++) begin
         logic [AW-1:0] a;
         a = AW'(k);
         if (inst == 0) q0.push_back({a, 16'(k) ^ 16'hA5A5});
         else           q1.push_back({a, 16'(k) ^ 16'hA5A5});
      end
   endtask

   always @(negedge clk) begin
      logic [AW+15:0] e;
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
      if (dst_we0) begin
         we_cnt0++;
         vectors++;
         if (q0.size() == 0) begin
            miscompares++;
            $display("FAIL wr0_unexpected: got addr %0d data %h, required no write", dst_addr0,
                     dst_dout0);
         end else begin
            e = q0.pop_front();
            if ({dst_addr0, dst_dout0} !== e) begin
               miscompares++;
               $display("FAIL wr0_word: got %0d/%h, required %0d/%h", dst_addr0, dst_dout0,
                        e[AW+15:16], e[15:0]);
            end
         end
      end
      if (dst_we1) begin
         we_cnt1++;
         vectors++;
         if (q1.size() == 0) begin
            miscompares++;
            $display("FAIL wr1_unexpected: got addr %0d data %h, required no write", dst_addr1,
                     dst_dout1);
         end else begin
            e = q1.pop_front();
            if ({dst_addr1, dst_dout1} !== e) begin
               miscompares++;
               $display("FAIL wr1_word: got %0d/%h, required %0d/%h", dst_addr1, dst_dout1,
                        e[AW+15:16], e[15:0]);
            end
         end
      end
   end

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({src_addr0, dst_addr0, dst_we0, busy0, done0} !== '0) begin
         miscompares++;
         $display("FAIL reset0: got %h, required 0", {src_addr0, dst_addr0, dst_we0, busy0, done0});
      end
      vectors++;
      if ({src_addr1, dst_addr1, dst_we1, busy1, done1} !== '0) begin
         miscompares++;
         $display("FAIL reset1: got %h, required 0", {src_addr1, dst_addr1, dst_we1, busy1, done1});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      int lat, w, d;
      w = we_cnt0; d = done_cnt0;
      push_copy(0);
      obj_copy0 = 1'b1;
      @(negedge clk);
      obj_copy0 = 1'b0;
      lat = 0;
      vectors++;
      if (busy0 !== 1'b0) begin
         miscompares++; $display("FAIL basic_busy_lat0: got %b, required 0", busy0);
      end
      @(negedge clk); lat++;
      vectors++;
      if ({busy0, dst_we0, src_addr0} !== {1'b1, 1'b0, AW'(0)}) begin
         miscompares++;
         $display("FAIL basic_lat1: got busy %b we %b addr %0d, required 1 0 0", busy0, dst_we0,
                  src_addr0);
      end
      @(negedge clk); lat++;
      vectors++;
      if ({dst_we0, dst_addr0} !== {1'b1, AW'(0)}) begin
         miscompares++;
         $display("FAIL basic_first_we: got we %b addr %0d, required 1 0", dst_we0, dst_addr0);
      end
      while (!done0 && lat < 3000) begin @(negedge clk); lat++; end
      vectors++;
      if (lat != int'(NW) + 2) begin
         miscompares++; $display("FAIL basic_done_lat: got %0d, required %0d", lat, NW + 2);
      end
      vectors++;
      if (busy0 !== 1'b0) begin
         miscompares++; $display("FAIL basic_busy_fall: got %b, required 0", busy0);
      end
      @(negedge clk);
      vectors++;
      if (done0 !== 1'b0) begin
         miscompares++; $display("FAIL basic_done_width: got %b, required 0", done0);
      end
      vectors++;
      if (we_cnt0 - w != int'(NW) || done_cnt0 - d != 1 || q0.size() != 0) begin
         miscompares++;
         $display("FAIL basic_counts: got writes %0d dones %0d left %0d, required %0d 1 0",
                  we_cnt0 - w, done_cnt0 - d, q0.size(), NW);
      end
   endtask

   task automatic test_vbwait;
      int bad, k, w, d;
      w = we_cnt1; d = done_cnt1; bad = 0;
      lvbl1 = 1'b1;
      push_copy(1);
      obj_copy1 = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         obj_copy1 = 1'b0;
         if (dst_we1 || (i >= 1 && !busy1)) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL vb_hold: got %0d bad cycles, required 0", bad);
      end
      lvbl1 = 1'b0;
      k = 0;
      while (!dst_we1 && k < 20) begin @(negedge clk); k++; end
      vectors++;
      if (k != 2) begin
         miscompares++; $display("FAIL vb_start_lat: got %0d, required 2", k);
      end
      k = 0;
      while (we_cnt1 - w < 300 && k < 2000) begin @(negedge clk); k++; end
      lvbl1 = 1'b1;
      k = 0;
      while (!done1 && k < 2000) begin @(negedge clk); k++; end
      @(negedge clk);
      vectors++;
      if (we_cnt1 - w != int'(NW) || done_cnt1 - d != 1 || q1.size() != 0 || busy1 !== 1'b0)
      begin
         miscompares++;
         $display("FAIL vb_counts: got writes %0d dones %0d left %0d busy %b, required %0d 1 0 0",
                  we_cnt1 - w, done_cnt1 - d, q1.size(), busy1, NW);
      end
   endtask

   task automatic test_pending;
      int w, d;
      w = we_cnt0; d = done_cnt0;
      push_copy(0);
      obj_copy0 = 1'b1;
      @(negedge clk);
      obj_copy0 = 1'b0;
      repeat (100) @(negedge clk);
      push_copy(0);
      for (int i = 0; i < 3; i++) begin
         obj_copy0 = 1'b1;
         @(negedge clk);
         obj_copy0 = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (3500) @(negedge clk);
      vectors++;
      if (done_cnt0 - d != 2) begin
         miscompares++; $display("FAIL pend_dones: got %0d, required 2", done_cnt0 - d);
      end
      vectors++;
      if (we_cnt0 - w != 2 * int'(NW) || q0.size() != 0 || busy0 !== 1'b0) begin
         miscompares++;
         $display("FAIL pend_writes: got %0d left %0d busy %b, required %0d 0 0", we_cnt0 - w,
                  q0.size(), busy0, 2 * NW);
      end
   endtask

   task automatic test_hold;
      int w, d;
      w = we_cnt0; d = done_cnt0;
      push_copy(0);
      obj_copy0 = 1'b1;
      repeat (5000) @(negedge clk);
      obj_copy0 = 1'b0;
      repeat (10) @(negedge clk);
      vectors++;
      if (done_cnt0 - d != 1 || we_cnt0 - w != int'(NW) || q0.size() != 0) begin
         miscompares++;
         $display("FAIL hold: got dones %0d writes %0d left %0d, required 1 %0d 0", done_cnt0 - d,
                  we_cnt0 - w, q0.size(), NW);
      end
   endtask

   task automatic test_rst_mid;
      int k, w;
      w = we_cnt0;
      push_copy(0);
      obj_copy0 = 1'b1;
      @(negedge clk);
      obj_copy0 = 1'b0;
      k = 0;
      while (we_cnt0 - w < 512 && k < 2000) begin @(negedge clk); k++; end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({busy0, dst_we0, src_addr0, done0} !== '0) begin
         miscompares++;
         $display("FAIL rst_mid: got busy %b we %b addr %0d done %b, required 0 0 0 0", busy0,
                  dst_we0, src_addr0, done0);
      end
      q0.delete();
      rst = 1'b0;
      @(negedge clk);
      w = we_cnt0;
      push_copy(0);
      obj_copy0 = 1'b1;
      @(negedge clk);
      obj_copy0 = 1'b0;
      k = 0;
      while (!done0 && k < 3000) begin @(negedge clk); k++; end
      vectors++;
      if (!done0 || we_cnt0 - w != int'(NW) || q0.size() != 0) begin
         miscompares++;
         $display("FAIL rst_recopy: got done %b writes %0d left %0d, required 1 %0d 0", done0,
                  we_cnt0 - w, q0.size(), NW);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int k, w, d;
      w = we_cnt0; d = done_cnt0;
      push_copy(0);
      obj_copy0 = 1'b1;
      @(negedge clk);
      obj_copy0 = 1'b0;
      k = 0;
      while (!(dst_we0 && dst_addr0 == AW'(NW - 1)) && k < 3000) begin @(negedge clk); k++; end
      // Edge is sampled on the same clock that raises done
      obj_copy0 = 1'b1;
      push_copy(0);
      @(negedge clk);
      obj_copy0 = 1'b0;
      vectors++;
      if ({done0, busy0} !== 2'b10) begin
         miscompares++; $display("FAIL b2b_done: got done %b busy %b, required 1 0", done0, busy0);
      end
      @(negedge clk);
      vectors++;
      if ({busy0, src_addr0} !== {1'b1, AW'(0)}) begin
         miscompares++;
         $display("FAIL b2b_restart: got busy %b addr %0d, required 1 0", busy0, src_addr0);
      end
      k = 0;
      while (!done0 && k < 3000) begin @(negedge clk); k++; end
      @(negedge clk);
      vectors++;
      if (done_cnt0 - d != 2 || we_cnt0 - w != 2 * int'(NW) || q0.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_counts: got dones %0d writes %0d left %0d, required 2 %0d 0",
                  done_cnt0 - d, we_cnt0 - w, q0.size(), 2 * NW);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_vbwait;
      test_pending;
      test_hold;
      test_rst_mid;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
